// File: rtl/fifo_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_stream_reader
// Brief    : Drains a non-showahead FIFO read port into a valid/ready stream
//            through a small skid buffer that hides the one-cycle q latency.
// Revision : 1.0
// ============================================================================
module fifo_stream_reader #(
    parameter int DATA_LEN  = 16,
    parameter int BUF_DEPTH = 3,
    parameter int CNT_LEN   = 32
) (
    input  logic                           clk,
    input  logic                           reset_n,
    output logic                           fifo_rd_en,
    input  logic                           fifo_rd_empty,
    input  logic [DATA_LEN-1:0]            fifo_data_out,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_LEN-1:0]            out_data,
    output logic [$clog2(BUF_DEPTH+1)-1:0] occupancy,
    output logic [CNT_LEN-1:0]             word_count
);

    localparam int                 c_OCC_W    = $clog2(BUF_DEPTH + 1);
    localparam int                 c_PTR_W    = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(BUF_DEPTH - 1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_OCC_W-1:0] c_OCC_ONE  = c_OCC_W'(1);
    localparam logic [c_OCC_W:0]   c_DEPTH    = (c_OCC_W + 1)'(BUF_DEPTH);
    localparam logic [CNT_LEN-1:0] c_CNT_ONE  = CNT_LEN'(1);

    logic [c_OCC_W-1:0]  occ_q;
    logic [c_OCC_W-1:0]  occ_d;
    logic                inflight_q;
    logic [c_PTR_W-1:0]  wr_ptr_q;
    logic [c_PTR_W-1:0]  rd_ptr_q;
    logic [DATA_LEN-1:0] buf_q [BUF_DEPTH];
    logic [CNT_LEN-1:0]  word_count_q;

    logic                w_pop;
    logic [c_OCC_W:0]    w_reserved;

    function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] ptr);
        return (ptr == c_PTR_LAST) ? '0 : ptr + c_PTR_ONE;
    endfunction

    // Slots are reserved for the in-flight word, so a read is only issued when
    // its data is guaranteed a place; out_ready never reaches fifo_rd_en.
    assign w_reserved = {1'b0, occ_q} + {{c_OCC_W{1'b0}}, inflight_q};
    assign fifo_rd_en = reset_n && !fifo_rd_empty && (w_reserved < c_DEPTH);

    assign out_valid  = (occ_q != '0);
    assign w_pop      = out_valid && out_ready;
    assign out_data   = buf_q[rd_ptr_q];
    assign occupancy  = occ_q;
    assign word_count = word_count_q;

    always_comb begin
        occ_d = occ_q;
        case ({inflight_q, w_pop})
            2'b10:   occ_d = occ_q + c_OCC_ONE;
            2'b01:   occ_d = occ_q - c_OCC_ONE;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            occ_q        <= '0;
            inflight_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            word_count_q <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            occ_q      <= occ_d;
            inflight_q <= fifo_rd_en;
            if (inflight_q) begin
                buf_q[wr_ptr_q] <= fifo_data_out;
                wr_ptr_q        <= next_ptr(wr_ptr_q);
            end
            if (w_pop) begin
                rd_ptr_q     <= next_ptr(rd_ptr_q);
                word_count_q <= word_count_q + c_CNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire
